// File: rtl/simple_fifo_reader.sv
// simple_fifo_reader: drains simple_fifo into a valid/ready stream through a
// 2-entry prefetch buffer, flags burst ends with m_last and counts words delivered.
`default_nettype none

module simple_fifo_reader #(
    parameter int WIDTH     = 64,
    parameter int BURST_LEN = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 fifo_re,
    input  logic [WIDTH-1:0]     fifo_dout,
    input  logic                 fifo_empty,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic [CNT_WIDTH-1:0] words_out,
    output logic                 busy
);

    localparam int            BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);

    logic [1:0]       buf_count;
    logic             inflight;
    logic [WIDTH-1:0] skid_data;
    logic [BW-1:0]    burst_cnt;

    logic             pop;
    logic [2:0]       occupancy;
    logic [1:0]       count_next;
    logic [BW-1:0]    burst_next;

    assign pop       = m_valid & m_ready;
    // Words held or pending after this edge; a read is only issued if it will fit.
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_re   = reset & enable & ~fifo_empty & (occupancy < 3'd2);

    always_comb begin
        count_next = buf_count;
        case ({inflight, pop})
            2'b10:   if (buf_count != 2'd2) count_next = buf_count + 2'd1;
            2'b01:   count_next = buf_count - 2'd1;
            default: count_next = buf_count;
        endcase
    end

    always_comb begin
        burst_next = burst_cnt;
        if (pop) begin
            burst_next = (burst_cnt == LAST_IDX) ? '0 : burst_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_count <= 2'd0;
            inflight  <= 1'b0;
            burst_cnt <= '0;
            skid_data <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            words_out <= '0;
            busy      <= 1'b0;
        end else begin
            buf_count <= count_next;
            inflight  <= fifo_re;
            burst_cnt <= burst_next;
            m_valid   <= (count_next != 2'd0);
            m_last    <= (count_next != 2'd0) && (burst_next == LAST_IDX);
            busy      <= (count_next != 2'd0) || fifo_re;

            if (pop) begin
                words_out <= words_out + CNT_WIDTH'(1);
            end

            if (pop && (buf_count == 2'd2)) begin
                m_data <= skid_data;
            end

            // A captured word goes straight to the head when the head is free
            // (empty, or its only word is leaving); otherwise it queues behind.
            if (inflight) begin
                if ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop)) begin
                    m_data <= fifo_dout;
                end else begin
                    skid_data <= fifo_dout;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_simple_fifo_reader.sv
// tb_simple_fifo_reader: queue-based FIFO model and stream scoreboard around
// simple_fifo_reader, with one task per scenario.
`default_nettype none

module tb_simple_fifo_reader;

    localparam int WIDTH     = 64;
    localparam int BURST_LEN = 8;
    localparam int CNT_WIDTH = 32;
    localparam int MAXLOG    = 2048;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 fifo_re;
    logic [WIDTH-1:0]     fifo_dout;
    logic                 fifo_empty;
    logic [WIDTH-1:0]     m_data;
    logic                 m_valid;
    logic                 m_last;
    logic                 m_ready;
    logic [CNT_WIDTH-1:0] words_out;
    logic                 busy;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];

    int                   cyc        = 0;
    int                   re_total   = 0;
    int                   xfer_total = 0;
    int                   rd_since   = 0;
    logic [CNT_WIDTH-1:0] mon_words  = '0;
    int                   re_cyc   [MAXLOG];
    int                   xfer_cyc [MAXLOG];
    bit                   xfer_last[MAXLOG];

    simple_fifo_reader #(
        .WIDTH    (WIDTH),
        .BURST_LEN(BURST_LEN),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .fifo_re   (fifo_re),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .words_out (words_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // Samples at the falling edge, then plays the FIFO's registered read port
    // just after the rising edge.
    task automatic model_loop();
        bit               do_re;
        bit               stall;
        bit               exp_last;
        logic [WIDTH-1:0] hold_data;
        bit               hold_last;
        logic [WIDTH-1:0] e;
        int               occ;
        stall = 0;
        hold_data = '0;
        hold_last = 0;
        forever begin
            @(negedge clk);
            do_re = 0;
            if (!reset) begin
                mon_words = '0;
                stall     = 0;
                checks++;
                if (fifo_re !== 1'b0) begin
                    errors++;
                    $display("FAIL re_in_reset: fifo_re=%b required 0", fifo_re);
                end
            end else begin
                checks++;
                if (words_out !== mon_words) begin
                    errors++;
                    $display("FAIL words_out: got %0d required %0d", words_out, mon_words);
                end
                occ = rd_since - int'(mon_words);
                checks++;
                if (busy !== (occ != 0)) begin
                    errors++;
                    $display("FAIL busy: got %b required %b (held+pending=%0d)", busy, occ != 0, occ);
                end
                checks++;
                if (occ > 2 || occ < 0) begin
                    errors++;
                    $display("FAIL occupancy: got %0d required 0..2", occ);
                end
                if (fifo_re === 1'b1) begin
                    checks++;
                    if (fifo_empty !== 1'b0) begin
                        errors++;
                        $display("FAIL re_while_empty: fifo_empty=%b required 0", fifo_empty);
                    end
                    do_re = 1;
                    if (re_total < MAXLOG) re_cyc[re_total] = cyc;
                    re_total++;
                end
                if (stall) begin
                    checks++;
                    if (m_valid !== 1'b1 || m_data !== hold_data || m_last !== hold_last) begin
                        errors++;
                        $display("FAIL hold: got v=%b d=%0h l=%b required v=1 d=%0h l=%b",
                                 m_valid, m_data, m_last, hold_data, hold_last);
                    end
                end
                if (m_valid === 1'b1) begin
                    exp_last = ((mon_words % BURST_LEN) == BURST_LEN - 1);
                    checks++;
                    if (m_last !== exp_last) begin
                        errors++;
                        $display("FAIL m_last: got %b required %b at word %0d", m_last, exp_last, mon_words);
                    end
                    if (m_ready === 1'b1) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL extra_word: got %0h required none", m_data);
                        end else begin
                            e = exp_q.pop_front();
                            if (m_data !== e) begin
                                errors++;
                                $display("FAIL m_data: got %0h required %0h", m_data, e);
                            end
                        end
                        if (xfer_total < MAXLOG) begin
                            xfer_cyc[xfer_total]  = cyc;
                            xfer_last[xfer_total] = m_last;
                        end
                        xfer_total++;
                        mon_words = mon_words + 1'b1;
                    end
                end
                stall     = (m_valid === 1'b1) && (m_ready !== 1'b1);
                hold_data = m_data;
                hold_last = m_last;
            end

            @(posedge clk);
            #1;
            cyc++;
            if (!reset) begin
                fifo_q.delete();
                rd_since = 0;
            end else if (do_re && fifo_q.size() > 0) begin
                fifo_dout = fifo_q.pop_front();
                rd_since++;
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (exp_q.size() == 0 && busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        #1;
        checks++;
        if ({m_valid, m_last, busy, fifo_re} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got v/l/busy/re=%b%b%b%b required 0000", m_valid, m_last, busy, fifo_re);
        end
        checks++;
        if (m_data !== '0 || words_out !== '0) begin
            errors++;
            $display("FAIL reset_values: got data=%0h words=%0d required 0/0", m_data, words_out);
        end
        tick();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || words_out !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: got v=%b busy=%b words=%0d required 0/0/0", m_valid, busy, words_out);
        end
    endtask

    task automatic test_basic();
        int r0, x0;
        bit ok;
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        r0 = re_total;
        x0 = xfer_total;
        push(64'h11);
        push(64'h22);
        push(64'h33);
        wait_idle(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: got busy=%b required drain", busy); end
        checks++;
        if (re_total - r0 != 3 || re_cyc[r0 + 2] - re_cyc[r0] != 2) begin
            errors++;
            $display("FAIL basic_reads: got %0d reads required 3 consecutive", re_total - r0);
        end
        checks++;
        if (xfer_total - x0 != 3 || xfer_cyc[x0 + 2] - xfer_cyc[x0] != 2) begin
            errors++;
            $display("FAIL basic_stream: got %0d words required 3 consecutive", xfer_total - x0);
        end
        checks++;
        if (xfer_cyc[x0] - re_cyc[r0] != 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d required 2", xfer_cyc[x0] - re_cyc[r0]);
        end
        checks++;
        if (words_out !== 32'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: got words=%0d busy=%b required 3/0", words_out, busy);
        end
    endtask

    task automatic test_burst20();
        int x0, nlast;
        bit ok;
        do_reset();
        enable  = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) push({$urandom, $urandom});
        repeat (2) tick();
        x0 = xfer_total;
        enable = 1'b1;
        wait_idle(60, ok);
        checks++;
        if (!ok || xfer_total - x0 != 20) begin
            errors++;
            $display("FAIL burst_count: got %0d words required 20", xfer_total - x0);
        end
        checks++;
        if (xfer_cyc[x0 + 19] - xfer_cyc[x0] != 19) begin
            errors++;
            $display("FAIL burst_rate: got span %0d required 19", xfer_cyc[x0 + 19] - xfer_cyc[x0]);
        end
        nlast = 0;
        for (int i = 0; i < 20; i++) nlast += int'(xfer_last[x0 + i]);
        checks++;
        if (nlast != 2 || !xfer_last[x0 + 7] || !xfer_last[x0 + 15]) begin
            errors++;
            $display("FAIL burst_last: got %0d lasts required words 8 and 16", nlast);
        end
        checks++;
        if (words_out !== 32'd20) begin
            errors++;
            $display("FAIL burst_words: got %0d required 20", words_out);
        end
    endtask

    task automatic test_backpressure();
        int r0, x0;
        bit ok;
        logic [WIDTH-1:0] w0;
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b0;
        r0 = re_total;
        x0 = xfer_total;
        w0 = {$urandom, $urandom};
        push(w0);
        for (int i = 1; i < 5; i++) push({$urandom, $urandom});
        repeat (6) tick();
        checks++;
        if (re_total - r0 != 2) begin
            errors++;
            $display("FAIL bp_reads: got %0d required 2", re_total - r0);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== w0) begin
            errors++;
            $display("FAIL bp_head: got v=%b d=%0h required 1/%0h", m_valid, m_data, w0);
        end
        m_ready = 1'b1;
        wait_idle(40, ok);
        checks++;
        if (!ok || xfer_total - x0 != 5 || words_out !== 32'd5) begin
            errors++;
            $display("FAIL bp_drain: got %0d words required 5", xfer_total - x0);
        end
    endtask

    task automatic test_random();
        int x0, pushed;
        bit ok;
        do_reset();
        enable = 1'b1;
        x0     = xfer_total;
        pushed = 0;
        for (int i = 0; i < 3000 && (xfer_total - x0) < 200; i++) begin
            if (pushed < 200 && $urandom_range(0, 3) != 0) begin
                push({$urandom, $urandom});
                pushed++;
            end
            m_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        m_ready = 1'b1;
        wait_idle(40, ok);
        checks++;
        if (!ok || xfer_total - x0 != 200 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_count: got %0d words required 200", xfer_total - x0);
        end
        checks++;
        if (words_out !== 32'd200) begin
            errors++;
            $display("FAIL rand_words: got %0d required 200", words_out);
        end
    endtask

    task automatic test_enable();
        int r0, x0, r1;
        bit ok;
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        r0 = re_total;
        x0 = xfer_total;
        for (int i = 0; i < 10; i++) push({$urandom, $urandom});
        for (int i = 0; i < 40 && (xfer_total - x0) < 3; i++) tick();
        enable = 1'b0;
        r1 = re_total;
        checks++;
        if (busy !== 1'b1 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL en_midstream: got busy=%b v=%b required 1/1", busy, m_valid);
        end
        repeat (6) tick();
        checks++;
        if (re_total != r1) begin
            errors++;
            $display("FAIL en_no_read: got %0d reads after disable required 0", re_total - r1);
        end
        checks++;
        if (busy !== 1'b0 || (xfer_total - x0) != (re_total - r0) || fifo_q.size() == 0) begin
            errors++;
            $display("FAIL en_drain: got %0d words for %0d reads, busy=%b", xfer_total - x0, re_total - r0, busy);
        end
        enable = 1'b1;
        wait_idle(40, ok);
        checks++;
        if (!ok || xfer_total - x0 != 10 || words_out !== 32'd10) begin
            errors++;
            $display("FAIL en_resume: got %0d words required 10", xfer_total - x0);
        end
    endtask

    task automatic test_reset_mid();
        int x0, nlast;
        bit ok;
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        x0 = xfer_total;
        for (int i = 0; i < 12; i++) push({$urandom, $urandom});
        for (int i = 0; i < 40 && (xfer_total - x0) < 3; i++) tick();
        m_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (m_valid !== 1'b1 || busy !== 1'b1 || words_out == '0) begin
            errors++;
            $display("FAIL mid_setup: got v=%b busy=%b words=%0d required 1/1/>0", m_valid, busy, words_out);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_last, busy, fifo_re} !== 4'b0000 || words_out !== '0) begin
            errors++;
            $display("FAIL mid_async: got v/l/busy/re=%b%b%b%b words=%0d required 0000/0",
                     m_valid, m_last, busy, fifo_re, words_out);
        end
        fifo_q.delete();
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        x0 = xfer_total;
        for (int i = 0; i < 16; i++) push({$urandom, $urandom});
        m_ready = 1'b1;
        wait_idle(60, ok);
        nlast = 0;
        for (int i = 0; i < 8; i++) nlast += int'(xfer_last[x0 + i]);
        checks++;
        if (!ok || nlast != 1 || !xfer_last[x0 + 7]) begin
            errors++;
            $display("FAIL mid_last: got %0d lasts in first 8 required only word 8", nlast);
        end
        checks++;
        if (xfer_total - x0 != 16 || words_out !== 32'd16) begin
            errors++;
            $display("FAIL mid_words: got %0d required 16", words_out);
        end
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        fork
            model_loop();
        join_none
        test_reset();
        test_basic();
        test_burst20();
        test_backpressure();
        test_random();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/simple_fifo_reader.md
Name: simple_fifo_reader

Overview:
- Read-side companion to simple_fifo. Drains the FIFO through its re/dout/empty port and presents the words on a valid/ready stream toward the consuming block.
- Hides the FIFO's one-cycle read latency behind a 2-entry prefetch/skid buffer, so a continuously ready consumer receives one word per clock.
- Marks burst boundaries with m_last and counts delivered words.

Parameters:
- WIDTH, 64: data width; must match the attached simple_fifo.
- BURST_LEN, 8: m_last is asserted on every BURST_LEN-th delivered word; must be >= 1.
- CNT_WIDTH, 32: width of words_out.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  when high, the block may issue FIFO reads; when low, no new reads are issued.
- fifo_re  output  1  read strobe to simple_fifo.re.
- fifo_dout  input  WIDTH  from simple_fifo.dout; valid exactly one cycle after fifo_re is sampled high.
- fifo_empty  input  1  from simple_fifo.empty; registered, and reflects any read accepted on the previous edge.
- m_data  output  WIDTH  stream data.
- m_valid  output  1  stream valid.
- m_last  output  1  qualifies m_data as the final word of a burst.
- m_ready  input  1  consumer accept.
- words_out  output  CNT_WIDTH  number of words transferred so far; wraps at 2^CNT_WIDTH.
- busy  output  1  high while buf_count + inflight != 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - Registered outputs: m_valid=0, m_data=0, m_last=0, words_out=0, busy=0.
  - Internal state: buf_count=0, inflight=0, burst_cnt=0.
  - fifo_re is forced to 0 while reset is low.
  - Words held in the buffer or in flight are discarded; the FIFO is assumed to be reset alongside this block.
- Internal state:
  - buf_count: 0..2, words held.
  - inflight: 0..1, read issued last cycle.
  - pop = m_valid & m_ready.
- Read issue (combinational):
  - fifo_re = enable & ~fifo_empty & ((buf_count + inflight - pop) < 2).
  - Never read while fifo_empty=1. The buffer can never overflow.
- Capture: if inflight=1, fifo_dout is written into the buffer on that edge. inflight(next) = fifo_re.
- Buffer:
  - 2-entry FIFO order. Head drives m_data/m_last. m_valid = (buf_count != 0), registered.
  - Simultaneous capture and pop: buf_count unchanged, and the head advances correctly. With buf_count=1, the captured word becomes the head on the next cycle.
  - m_data/m_valid/m_last stay stable while m_valid=1 and m_ready=0 (AXI-style hold rule).
- Latency: FIFO non-empty with an idle block -> fifo_re in the same cycle -> m_valid high 2 edges later (1 for FIFO latency, 1 for the buffer register).
- Throughput: with m_ready held high and the FIFO never empty, one word per clock after the initial latency.
- m_last:
  - m_last = (burst_cnt == BURST_LEN-1) for the head word, computed when the word enters the head position.
  - burst_cnt advances on each pop and wraps to 0 after BURST_LEN-1.
  - BURST_LEN=1 makes m_last permanently high with m_valid.
- words_out: increments by 1 on each pop; modulo 2^CNT_WIDTH.
- enable deassertion:
  - Stops new fifo_re immediately (combinational).
  - In-flight and buffered words still drain normally.
  - Re-assertion resumes with no loss or duplication.
- fifo_empty rising while a read is in flight: that read is still captured; no further reads are issued.
- busy reflects registered state; low only when no data is held or pending.

Test Plan:
- Reset, then load 3 words (0x11, 0x22, 0x33), m_ready=1, enable=1 -> fifo_re on 3 consecutive cycles; m_valid high for 3 consecutive cycles with data 0x11, 0x22, 0x33 in order; words_out=3; busy returns to 0.
- Preload 20 words, m_ready=1 -> after 2-cycle fill, 20 transfers in 20 consecutive cycles; m_last on words 8 and 16 (BURST_LEN=8); words_out=20.
- Backpressure: 5 words queued, m_ready=0 for 6 cycles -> fifo_re issued exactly twice, buf_count=2, m_data held at word 0. Release m_ready -> all 5 delivered in order, no duplicates.
- Random m_ready at 50% over 200 words -> scoreboard matches FIFO order exactly; fifo_re never sampled while fifo_empty=1; buf_count never exceeds 2.
- enable dropped mid-stream with 1 word in flight and 1 buffered -> both delivered, no further fifo_re. enable reasserted -> stream continues with the next FIFO word.
- reset pulsed low mid-burst with buf_count=2 -> m_valid, m_last, words_out and busy go to 0 asynchronously without waiting for a clock edge; fifo_re=0 during reset; after release the next burst's m_last falls on its 8th word.
